// File: rtl/pwm_pkg.sv
// Shared constants and the per-channel output rule for the 16-channel PWM peripheral.
package pwm_pkg;

  localparam int NUM_CH = 16;
  localparam int CNT_W = 8;
  localparam logic [7:0] DUTY_FULL = 8'hFF;
  localparam logic [7:0] DUTY_ZERO = 8'h00;

  // A disabled channel is always low, even when it is in PWM mode.
  function automatic logic [NUM_CH-1:0] channel_drive(
    input logic [NUM_CH-1:0] en_out,
    input logic [NUM_CH-1:0] en_pwm,
    input logic level
  );
    return en_out & (~en_pwm | {NUM_CH{level}});
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// Register-side bundle feeding the PWM peripheral: enables and the shared duty value.
interface pwm_peripheral_if;
  import pwm_pkg::*;

  logic [7:0]       en_reg_out_7_0;
  logic [7:0]       en_reg_out_15_8;
  logic [7:0]       en_reg_pwm_7_0;
  logic [7:0]       en_reg_pwm_15_8;
  logic [CNT_W-1:0] pwm_duty_cycle;

  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle
  );

  modport slave (
    input en_reg_out_7_0,
    input en_reg_out_15_8,
    input en_reg_pwm_7_0,
    input en_reg_pwm_15_8,
    input pwm_duty_cycle
  );

endinterface

// File: rtl/pwm_prescaler.sv
// Free-running divider: counts 0..PRESCALE-1 and flags the last count as the PWM step tick.
module pwm_prescaler #(
  parameter int PRESCALE = 13
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  // PRESCALE=1 keeps count pinned at zero, so tick is asserted every cycle.
  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM: one shared counter and duty, per-channel enable/mode, registered outputs.
module pwm_peripheral #(
  parameter int PRESCALE = 13,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  pwm_peripheral_if.slave         bus,
  output logic [15:0]             out,
  output logic                    period_start
);
  import pwm_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              tick;
  logic              period_end;
  logic              pwm_level;
  logic [CNT_W-1:0]  pwm_cnt;
  logic [CNT_W-1:0]  duty_shadow;
  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] en_pwm;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign en_out     = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm     = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
  assign period_end = tick && (pwm_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Duty is only picked up on the wrap so a period never mixes two duty values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_shadow  <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= period_end;
      if (period_end) begin
        duty_shadow <= bus.pwm_duty_cycle;
      end
    end
  end

  always_comb begin
    pwm_level = 1'b0;
    if (duty_shadow == DUTY_FULL) begin
      pwm_level = 1'b1;
    end else if (duty_shadow == DUTY_ZERO) begin
      pwm_level = 1'b0;
    end else begin
      pwm_level = (pwm_cnt < duty_shadow);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else begin
      out <= channel_drive(en_out, en_pwm, pwm_level);
    end
  end

endmodule
